// File: rtl/opacity_mask_buffer.sv
// opacity_mask_buffer
// Double-buffered per-car opacity mask store. The encoder's per-pixel opacity
// stream for CAR1/CAR2 is captured into the back bank; banks exchange only on
// an accepted swap, so the decoder always reads a complete, stable mask.
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_frame_start/i_frame_done      capture framing pulses
//   i_pixel_index/i_object_id/
//   i_opacity/i_opacity_valid       encoder pixel stream
//   i_swap                          front/back exchange request
//   i_rd1_h/v, i_rd2_h/v            decoder read coordinates (car1, car2)
//   o_rd1_opacity, o_rd2_opacity    registered front-bank read data
//   o_front_bank                    bank the decoder reads
//   o_busy, o_pending               FSM status
//   o_overrun, o_swap_miss          one-cycle event pulses
//   o_frame_count                   completed swaps (wraps)
module opacity_mask_buffer #(
  parameter int unsigned IMAGE_SIZE = 32,
  parameter int unsigned COOR_W     = 5,
  parameter int unsigned OBJ_W      = 3,
  parameter int unsigned CAR1_ID    = 1,
  parameter int unsigned CAR2_ID    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_frame_start,
  input  logic [2*COOR_W-1:0]   i_pixel_index,
  input  logic [OBJ_W-1:0]      i_object_id,
  input  logic                  i_opacity,
  input  logic                  i_opacity_valid,
  input  logic                  i_frame_done,
  input  logic                  i_swap,
  input  logic [COOR_W-1:0]     i_rd1_h,
  input  logic [COOR_W-1:0]     i_rd1_v,
  input  logic [COOR_W-1:0]     i_rd2_h,
  input  logic [COOR_W-1:0]     i_rd2_v,
  output logic                  o_rd1_opacity,
  output logic                  o_rd2_opacity,
  output logic                  o_front_bank,
  output logic                  o_busy,
  output logic                  o_pending,
  output logic                  o_overrun,
  output logic                  o_swap_miss,
  output logic [7:0]            o_frame_count
);

  localparam int unsigned NPIX  = IMAGE_SIZE * IMAGE_SIZE;
  localparam int unsigned IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PENDING = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic                        front_q, front_d;
  logic [7:0]                  frame_count_q, frame_count_d;
  logic                        overrun_q, overrun_d;
  logic                        swap_miss_q, swap_miss_d;
  logic                        busy_q, busy_d;
  logic                        pending_q, pending_d;
  logic                        rd1_q, rd1_d;
  logic                        rd2_q, rd2_d;
  // mask_q[bank][car][pixel], car 0 = CAR1, car 1 = CAR2
  logic [1:0][1:0][NPIX-1:0]   mask_q, mask_d;

  logic                        clear_c;
  logic                        wr_en_c;
  logic                        pix_ok_c;
  logic                        wr_car_c;
  logic [IDX_W-1:0]            wr_idx_c;
  logic                        clr_bank_c;
  logic                        wr_bank_c;
  logic [IDX_W-1:0]            rd1_idx_c, rd2_idx_c;
  logic                        rd1_ok_c, rd2_ok_c;

  // Pixel qualification: valid, in range, owned by one of the two cars
  always_comb begin
    pix_ok_c = i_opacity_valid
             && (32'(i_pixel_index) < NPIX)
             && ((i_object_id == OBJ_W'(CAR1_ID)) || (i_object_id == OBJ_W'(CAR2_ID)));
    wr_car_c = (i_object_id == OBJ_W'(CAR2_ID));
    wr_idx_c = IDX_W'(i_pixel_index);
  end

  // Next-state, status and event logic
  always_comb begin
    state_d       = state_q;
    front_d       = front_q;
    frame_count_d = frame_count_q;
    overrun_d     = 1'b0;
    swap_miss_d   = 1'b0;
    clear_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_frame_start) begin
          clear_c = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // A restart wins over a same-cycle done
        if (i_frame_start) begin
          clear_c   = 1'b1;
          overrun_d = 1'b1;
        end else if (i_frame_done) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (i_swap) begin
          front_d       = ~front_q;
          frame_count_d = frame_count_q + 8'd1;
          if (i_frame_start) begin
            clear_c = 1'b1;
            state_d = CAPTURE;
          end else begin
            state_d = IDLE;
          end
        end else if (i_frame_start) begin
          clear_c   = 1'b1;
          overrun_d = 1'b1;
          state_d   = CAPTURE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_swap && (state_q != PENDING)) swap_miss_d = 1'b1;

    // Writes only in CAPTURE, never in a clear cycle
    wr_en_c = (state_q == CAPTURE) && !i_frame_start && pix_ok_c;

    busy_d    = (state_d != IDLE);
    pending_d = (state_d == PENDING);
  end

  // Mask update: clear targets the back bank after any same-cycle swap
  always_comb begin
    clr_bank_c = ~front_d;
    wr_bank_c  = ~front_q;
    mask_d     = mask_q;
    if (clear_c) begin
      mask_d[clr_bank_c] = '0;
    end else if (wr_en_c) begin
      mask_d[wr_bank_c][wr_car_c][wr_idx_c] = i_opacity;
    end
  end

  // Front-bank read ports; out-of-range coordinates return 0
  always_comb begin
    rd1_ok_c  = (32'(i_rd1_h) < IMAGE_SIZE) && (32'(i_rd1_v) < IMAGE_SIZE);
    rd2_ok_c  = (32'(i_rd2_h) < IMAGE_SIZE) && (32'(i_rd2_v) < IMAGE_SIZE);
    rd1_idx_c = IDX_W'(32'(i_rd1_v) * IMAGE_SIZE + 32'(i_rd1_h));
    rd2_idx_c = IDX_W'(32'(i_rd2_v) * IMAGE_SIZE + 32'(i_rd2_h));
    rd1_d     = rd1_ok_c && mask_q[front_q][1'b0][rd1_idx_c];
    rd2_d     = rd2_ok_c && mask_q[front_q][1'b1][rd2_idx_c];
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      front_q       <= 1'b0;
      frame_count_q <= 8'd0;
      overrun_q     <= 1'b0;
      swap_miss_q   <= 1'b0;
      busy_q        <= 1'b0;
      pending_q     <= 1'b0;
      rd1_q         <= 1'b0;
      rd2_q         <= 1'b0;
      mask_q        <= '0;
    end else begin
      state_q       <= state_d;
      front_q       <= front_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      swap_miss_q   <= swap_miss_d;
      busy_q        <= busy_d;
      pending_q     <= pending_d;
      rd1_q         <= rd1_d;
      rd2_q         <= rd2_d;
      mask_q        <= mask_d;
    end
  end

  assign o_rd1_opacity = rd1_q;
  assign o_rd2_opacity = rd2_q;
  assign o_front_bank  = front_q;
  assign o_busy        = busy_q;
  assign o_pending     = pending_q;
  assign o_overrun     = overrun_q;
  assign o_swap_miss   = swap_miss_q;
  assign o_frame_count = frame_count_q;

endmodule

// File: tb/tb_opacity_mask_buffer.sv
// Directed bench for opacity_mask_buffer; read results are checked through an
// expected-value queue filled when a read address is driven.
module tb_opacity_mask_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_frame_start, i_opacity, i_opacity_valid, i_frame_done, i_swap;
  logic [9:0] i_pixel_index;
  logic [2:0] i_object_id;
  logic [4:0] i_rd1_h, i_rd1_v, i_rd2_h, i_rd2_v;
  logic       o_rd1_opacity, o_rd2_opacity, o_front_bank, o_busy, o_pending;
  logic       o_overrun, o_swap_miss;
  logic [7:0] o_frame_count;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];
  logic [7:0] exp_cnt;

  opacity_mask_buffer dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_frame_start(i_frame_start), .i_pixel_index(i_pixel_index),
    .i_object_id(i_object_id), .i_opacity(i_opacity),
    .i_opacity_valid(i_opacity_valid), .i_frame_done(i_frame_done),
    .i_swap(i_swap),
    .i_rd1_h(i_rd1_h), .i_rd1_v(i_rd1_v), .i_rd2_h(i_rd2_h), .i_rd2_v(i_rd2_v),
    .o_rd1_opacity(o_rd1_opacity), .o_rd2_opacity(o_rd2_opacity),
    .o_front_bank(o_front_bank), .o_busy(o_busy), .o_pending(o_pending),
    .o_overrun(o_overrun), .o_swap_miss(o_swap_miss),
    .o_frame_count(o_frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one read pair, then compare the registered result one cycle later
  task automatic rd(input logic [4:0] h1, input logic [4:0] v1,
                    input logic [4:0] h2, input logic [4:0] v2,
                    input logic e1, input logic e2);
    logic [1:0] e;
    i_rd1_h = h1; i_rd1_v = v1; i_rd2_h = h2; i_rd2_v = v2;
    exp_q.push_back({e1, e2});
    tick();
    e = exp_q.pop_front();
    chk("rd1", 32'(o_rd1_opacity), 32'(e[1]));
    chk("rd2", 32'(o_rd2_opacity), 32'(e[0]));
  endtask

  task automatic pix(input int idx, input int id, input logic op);
    i_pixel_index = 10'(idx); i_object_id = 3'(id); i_opacity = op;
    i_opacity_valid = 1'b1;
    tick();
    i_opacity_valid = 1'b0;
  endtask

  task automatic p_start();
    i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
  endtask

  task automatic p_done();
    i_frame_done = 1'b1; tick(); i_frame_done = 1'b0;
  endtask

  task automatic p_swap();
    i_swap = 1'b1; tick(); i_swap = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic front, input logic [7:0] cnt,
                            input logic busy, input logic pend);
    chk({tag, "_front"}, 32'(o_front_bank), 32'(front));
    chk({tag, "_count"}, 32'(o_frame_count), 32'(cnt));
    chk({tag, "_busy"}, 32'(o_busy), 32'(busy));
    chk({tag, "_pending"}, 32'(o_pending), 32'(pend));
  endtask

  initial begin
    i_frame_start = 0; i_opacity = 0; i_opacity_valid = 0; i_frame_done = 0;
    i_swap = 0; i_pixel_index = 0; i_object_id = 0;
    i_rd1_h = 0; i_rd1_v = 0; i_rd2_h = 0; i_rd2_v = 0;

    // Reset values
    #12;
    chk_status("rst", 1'b0, 8'd0, 1'b0, 1'b0);
    chk("rst_rd1", 32'(o_rd1_opacity), 0);
    chk("rst_rd2", 32'(o_rd2_opacity), 0);
    chk("rst_ovr", 32'(o_overrun), 0);
    chk("rst_miss", 32'(o_swap_miss), 0);
    rst_n = 1'b1;
    tick();

    // Basic capture: pixel in the start cycle must be dropped
    i_pixel_index = 10'd0; i_object_id = 3'd1; i_opacity = 1'b1; i_opacity_valid = 1'b1;
    p_start();
    chk_status("start", 1'b0, 8'd0, 1'b1, 1'b0);
    chk("start_ovr", 32'(o_overrun), 0);
    for (int i = 0; i < 1024; i++) begin
      i_pixel_index = 10'(i);
      i_object_id   = (i % 2 == 1) ? 3'd1 : 3'd2;
      i_opacity     = 1'((i % 2));
      tick();
    end
    i_opacity_valid = 1'b0;
    p_done();
    chk_status("done", 1'b0, 8'd0, 1'b1, 1'b1);
    rd(3, 0, 3, 0, 1'b0, 1'b0);
    i_swap = 1'b1;
    rd(3, 0, 3, 0, 1'b0, 1'b0);
    i_swap = 1'b0;
    chk_status("swap1", 1'b1, 8'd1, 1'b0, 1'b0);
    chk("swap1_miss", 32'(o_swap_miss), 0);
    rd(3, 0, 3, 0, 1'b1, 1'b0);
    rd(0, 0, 0, 0, 1'b0, 1'b0);
    rd(31, 31, 4, 0, 1'b1, 1'b0);
    rd(2, 0, 1, 0, 1'b0, 1'b0);

    // Filtering: bad id, invalid, and writes while PENDING are dropped
    p_start();
    pix(10, 3, 1'b1);
    pix(12, 0, 1'b1);
    i_pixel_index = 10'd14; i_object_id = 3'd1; i_opacity = 1'b1; i_opacity_valid = 1'b0;
    tick();
    pix(33, 2, 1'b1);
    p_done();
    pix(20, 1, 1'b1);
    p_swap();
    chk_status("filt", 1'b0, 8'd2, 1'b0, 1'b0);
    rd(10, 0, 10, 0, 1'b0, 1'b0);
    rd(12, 0, 14, 0, 1'b0, 1'b0);
    rd(20, 0, 1, 1, 1'b0, 1'b1);

    // Overrun: restart discards the partial frame
    p_start();
    chk("ovr_first", 32'(o_overrun), 0);
    pix(66, 1, 1'b1);
    p_start();
    chk("ovr_pulse", 32'(o_overrun), 1);
    tick();
    chk("ovr_clear", 32'(o_overrun), 0);
    pix(231, 2, 1'b1);
    p_done();
    p_swap();
    chk_status("ovr", 1'b1, 8'd3, 1'b0, 1'b0);
    rd(2, 2, 7, 7, 1'b0, 1'b1);

    // Swap gating in IDLE and CAPTURE
    p_swap();
    chk("miss_idle", 32'(o_swap_miss), 1);
    chk_status("miss_idle", 1'b1, 8'd3, 1'b0, 1'b0);
    tick();
    chk("miss_idle_end", 32'(o_swap_miss), 0);
    p_start();
    pix(5, 1, 1'b1);
    p_swap();
    chk("miss_cap", 32'(o_swap_miss), 1);
    chk_status("miss_cap", 1'b1, 8'd3, 1'b1, 1'b0);
    p_done();
    chk_status("pend2", 1'b1, 8'd3, 1'b1, 1'b1);

    // Simultaneous swap + start in PENDING
    i_swap = 1'b1; i_frame_start = 1'b1;
    rd(5, 0, 7, 7, 1'b0, 1'b1);
    i_swap = 1'b0; i_frame_start = 1'b0;
    chk_status("sim", 1'b0, 8'd4, 1'b1, 1'b0);
    chk("sim_ovr", 32'(o_overrun), 0);
    chk("sim_miss", 32'(o_swap_miss), 0);
    rd(5, 0, 7, 7, 1'b1, 1'b0);
    p_done();
    p_swap();
    chk_status("sim2", 1'b1, 8'd5, 1'b0, 1'b0);
    rd(5, 0, 7, 7, 1'b0, 1'b0);

    // Frame counter wrap over 256 swaps
    exp_cnt = 8'd5;
    for (int i = 0; i < 256; i++) begin
      p_start();
      p_done();
      p_swap();
      exp_cnt = exp_cnt + 8'd1;
      chk("wrap_cnt", 32'(o_frame_count), 32'(exp_cnt));
    end
    chk("wrap_front", 32'(o_front_bank), 1);

    // Async reset in the middle of a capture
    p_start();
    pix(1, 1, 1'b1);
    i_pixel_index = 10'd2; i_object_id = 3'd1; i_opacity = 1'b1; i_opacity_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_status("arst", 1'b0, 8'd0, 1'b0, 1'b0);
    chk("arst_ovr", 32'(o_overrun), 0);
    chk("arst_miss", 32'(o_swap_miss), 0);
    chk("arst_rd1", 32'(o_rd1_opacity), 0);
    chk("arst_rd2", 32'(o_rd2_opacity), 0);
    #1;
    rst_n = 1'b1;
    i_opacity_valid = 1'b0;
    tick();
    chk_status("arst_post", 1'b0, 8'd0, 1'b0, 1'b0);
    rd(1, 0, 1, 0, 1'b0, 1'b0);
    p_swap();
    chk("arst_swapmiss", 32'(o_swap_miss), 1);
    chk("arst_front", 32'(o_front_bank), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
